// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: steers ioctl bytes into 8 ROM regions, holds core reset.
// Define ROM_CHECKSUM_EN to build the mod-256 checksum accumulator and checker.
module rom_load_sequencer #(
    parameter int          REGION_SHIFT = 14,
    parameter logic [16:0] ROM_SIZE     = 17'h10000,
    parameter int          HOLD_CYCLES  = 4096,
    parameter logic [7:0]  EXP_SUM      = 8'h00
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic [REGION_SHIFT-1:0] rom_addr,
    output logic [7:0]              rom_data,
    output logic [7:0]              rom_we,
    output logic                    core_reset,
    output logic                    load_done,
    output logic [16:0]             byte_count,
    output logic                    overrun,
    output logic [7:0]              checksum,
    output logic                    checksum_ok
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        HOLD
    } state_t;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [24:0] ROM_LIMIT = {8'h00, ROM_SIZE};

    state_t        state;
    state_t        state_d;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_d;
    logic          start;
    logic          hold_end;
    logic          active;
    logic          in_range;
    logic          wr_ok;
    logic          wr_bad;
    logic [2:0]    region;
    logic [16:0]   cnt_d;
    logic          ovr_d;
    logic          ld_d;

    assign in_range = (ioctl_addr < ROM_LIMIT);
    assign region   = ioctl_addr[REGION_SHIFT+2:REGION_SHIFT];
    // The cycle that opens a load also carries a write
    assign active   = start || (state == LOAD);
    assign wr_ok    = active && ioctl_wr && in_range;
    assign wr_bad   = active && ioctl_wr && !in_range;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        start      = 1'b0;
        hold_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ioctl_download) begin
                    state_d = LOAD;
                    start   = 1'b1;
                end
            end
            LOAD: begin
                if (!ioctl_download) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
            HOLD: begin
                if (ioctl_download) begin
                    state_d = LOAD;
                    start   = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d  = IDLE;
                    hold_end = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = start ? 17'h00000 : byte_count;
        if (wr_ok && (cnt_d != 17'h1FFFF)) begin
            cnt_d = cnt_d + 17'h00001;
        end
        ovr_d = (start ? 1'b0 : overrun) | wr_bad;
        ld_d  = load_done;
        if (start) begin
            ld_d = 1'b0;
        end else if (hold_end) begin
            ld_d = (byte_count != 17'h00000);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_we     <= 8'h00;
            rom_addr   <= '0;
            rom_data   <= 8'h00;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            byte_count <= 17'h00000;
            overrun    <= 1'b0;
        end else begin
            rom_we <= wr_ok ? (8'h01 << region) : 8'h00;
            if (wr_ok) begin
                rom_addr <= ioctl_addr[REGION_SHIFT-1:0];
                rom_data <= ioctl_dout;
            end
            // Follows the registered state, so it lags transitions by one cycle
            core_reset <= (state != IDLE) || !load_done;
            load_done  <= ld_d;
            byte_count <= cnt_d;
            overrun    <= ovr_d;
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic       ok_q;

    always_comb begin
        sum_d = start ? 8'h00 : sum_q;
        if (wr_ok) begin
            sum_d = sum_d + ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
            ok_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ok_q  <= ld_d && (sum_d == EXP_SUM);
        end
    end

    assign checksum    = sum_q;
    assign checksum_ok = ok_q;
`else
    logic unused_exp_sum;

    assign unused_exp_sum = ^EXP_SUM;
    assign checksum       = 8'h00;
    assign checksum_ok    = 1'b1;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer with a short hold window.
// Expected values come from an address/byte-level model of the load.
module tb_rom_load_sequencer;

    localparam int HOLD = 16;
`ifdef ROM_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  rom_we;
    logic        core_reset;
    logic        load_done;
    logic [16:0] byte_count;
    logic        overrun;
    logic [7:0]  checksum;
    logic        checksum_ok;

    int errors = 0;
    int checks = 0;

    int          m_count;
    logic [7:0]  m_sum;
    bit          m_ovr;
    logic [13:0] m_off;
    logic [7:0]  m_data;

    rom_load_sequencer #(
        .REGION_SHIFT(14),
        .ROM_SIZE(17'h10000),
        .HOLD_CYCLES(HOLD),
        .EXP_SUM(8'h00)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .rom_we(rom_we),
        .core_reset(core_reset),
        .load_done(load_done),
        .byte_count(byte_count),
        .overrun(overrun),
        .checksum(checksum),
        .checksum_ok(checksum_ok)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input logic dl, input logic wr,
                        input logic [24:0] a, input logic [7:0] d);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = a;
        ioctl_dout     = d;
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [7:0] exp_cs(input logic [7:0] s);
        return CK_EN ? s : 8'h00;
    endfunction

    function automatic logic exp_ok(input bit done, input logic [7:0] s);
        return CK_EN ? (done && (s == 8'h00)) : 1'b1;
    endfunction

    task automatic m_start();
        m_count = 0;
        m_sum   = 8'h00;
        m_ovr   = 1'b0;
    endtask

    // Byte-level model: 16 KiB regions, 64 KiB accepted
    task automatic m_wr(input logic [24:0] a, input logic [7:0] d,
                        output logic [7:0] we);
        int ai;
        ai = int'(a);
        if (ai < 65536) begin
            m_count++;
            m_sum  = m_sum + d;
            m_off  = 14'(ai % 16384);
            m_data = d;
            we     = 8'(1 << (ai / 16384));
        end else begin
            m_ovr = 1'b1;
            we    = 8'h00;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        m_off = '0;
        m_data = '0;
        m_start();
        repeat (2) @(posedge clk_sys);
        #1;
        checks++; if (rom_we !== 8'h00) begin errors++; $display("FAIL rst_we got=%h exp=00", rom_we); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core got=%b exp=1", core_reset); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", load_done); end
        checks++; if (byte_count !== 17'h0) begin errors++; $display("FAIL rst_count got=%h exp=0", byte_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got=%b exp=0", overrun); end
        checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL rst_cs got=%h exp=00", checksum); end
        checks++; if ({rom_addr, rom_data} !== 22'h0) begin errors++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", rom_addr, rom_data); end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'($urandom_range(1, 0)),
                 25'($urandom_range(32'hFFFF, 0)), 8'($urandom));
            checks++;
            if (rom_we !== 8'h00 || core_reset !== 1'b1 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d got we=%h cr=%b ld=%b exp we=00 cr=1 ld=0",
                         i, rom_we, core_reset, load_done);
            end
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] dat [4];
        logic [7:0] we;
        int fall;
        dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_start();
        tick(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            repeat (3) begin
                tick(1'b1, 1'b0, '0, '0);
                checks++; if (rom_we !== 8'h00) begin errors++; $display("FAIL t2_gap_we got=%h exp=00", rom_we); end
            end
            tick(1'b1, 1'b1, 25'(i), dat[i]);
            m_wr(25'(i), dat[i], we);
            checks++;
            if (rom_we !== we || rom_addr !== m_off || rom_data !== m_data) begin
                errors++;
                $display("FAIL t2_wr%0d got=%h/%h/%h exp=%h/%h/%h",
                         i, rom_we, rom_addr, rom_data, we, m_off, m_data);
            end
        end
        tick(1'b0, 1'b0, '0, '0);
        fall = -1;
        for (int k = 1; k <= 40; k++) begin
            tick(1'b0, 1'b0, '0, '0);
            if (fall < 0 && core_reset === 1'b0) fall = k;
        end
        // one FLUSH cycle, HOLD cycles, one register stage
        checks++; if (fall != HOLD + 2) begin errors++; $display("FAIL t2_release got=%0d exp=%0d", fall, HOLD + 2); end
        checks++; if (byte_count !== 17'(m_count)) begin errors++; $display("FAIL t2_count got=%0d exp=%0d", byte_count, m_count); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL t2_done got=%b exp=1", load_done); end
        checks++; if (checksum !== exp_cs(m_sum)) begin errors++; $display("FAIL t2_cs got=%h exp=%h", checksum, exp_cs(m_sum)); end
        checks++; if (checksum_ok !== exp_ok(1'b1, m_sum)) begin errors++; $display("FAIL t2_ok got=%b exp=%b", checksum_ok, exp_ok(1'b1, m_sum)); end
    endtask

    task automatic test_random_load();
        logic [7:0]  we;
        logic [24:0] a;
        logic [7:0]  d;
        logic        wr;
        m_start();
        tick(1'b1, 1'b1, 25'h0C005, 8'h5A);
        m_wr(25'h0C005, 8'h5A, we);
        checks++;
        if (rom_we !== we || rom_addr !== m_off || rom_data !== m_data) begin
            errors++;
            $display("FAIL t3_region got=%h/%h/%h exp=%h/%h/%h",
                     rom_we, rom_addr, rom_data, we, m_off, m_data);
        end
        checks++; if (byte_count !== 17'(m_count)) begin errors++; $display("FAIL t3_start_count got=%0d exp=%0d", byte_count, m_count); end
        for (int i = 0; i < 60; i++) begin
            wr = ($urandom_range(3, 0) != 0);
            a  = 25'($urandom_range(32'h13FFF, 0));
            d  = 8'($urandom);
            tick(1'b1, wr, a, d);
            if (wr) m_wr(a, d, we);
            else we = 8'h00;
            checks++;
            if (rom_we !== we || rom_addr !== m_off || rom_data !== m_data ||
                byte_count !== 17'(m_count) || overrun !== m_ovr) begin
                errors++;
                $display("FAIL rnd_%0d got=%h/%h/%h/%0d/%b exp=%h/%h/%h/%0d/%b",
                         i, rom_we, rom_addr, rom_data, byte_count, overrun,
                         we, m_off, m_data, m_count, m_ovr);
            end
        end
        a = 25'($urandom_range(32'hFFFF, 0));
        tick(1'b0, 1'b1, a, 8'hC3);
        m_wr(a, 8'hC3, we);
        checks++; if (rom_we !== we) begin errors++; $display("FAIL fall_wr_we got=%h exp=%h", rom_we, we); end
        tick(1'b0, 1'b1, 25'h00001, 8'h01);
        checks++;
        if (rom_we !== 8'h00 || byte_count !== 17'(m_count)) begin
            errors++;
            $display("FAIL flush_wr got=%h/%0d exp=00/%0d", rom_we, byte_count, m_count);
        end
        repeat (HOLD + 1) tick(1'b0, 1'b0, '0, '0);
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0) begin errors++; $display("FAIL rnd_end got=%b/%b exp=1/0", load_done, core_reset); end
        checks++; if (checksum !== exp_cs(m_sum)) begin errors++; $display("FAIL rnd_cs got=%h exp=%h", checksum, exp_cs(m_sum)); end
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr got=%b exp=%b", overrun, m_ovr); end
    endtask

    task automatic test_overrun();
        logic [7:0] we;
        m_start();
        tick(1'b1, 1'b0, '0, '0);
        tick(1'b1, 1'b1, 25'h00123, 8'h01);
        m_wr(25'h00123, 8'h01, we);
        tick(1'b1, 1'b1, 25'h10000, 8'h77);
        m_wr(25'h10000, 8'h77, we);
        checks++;
        if (rom_we !== 8'h00 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL t4_oor got=%h/%b exp=00/1", rom_we, overrun);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 25'(16'h4000 * i + 7), 8'(i));
            m_wr(25'(16'h4000 * i + 7), 8'(i), we);
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL t4_sticky got=%b exp=1", overrun); end
        end
        tick(1'b0, 1'b0, '0, '0);
        repeat (HOLD + 2) tick(1'b0, 1'b0, '0, '0);
        checks++;
        if (overrun !== 1'b1 || load_done !== 1'b1 || byte_count !== 17'(m_count)) begin
            errors++;
            $display("FAIL t4_end got=%b/%b/%0d exp=1/1/%0d", overrun, load_done, byte_count, m_count);
        end
        m_start();
        tick(1'b1, 1'b0, '0, '0);
        checks++;
        if (overrun !== 1'b0 || load_done !== 1'b0 || byte_count !== 17'h0) begin
            errors++;
            $display("FAIL t4_clear got=%b/%b/%0d exp=0/0/0", overrun, load_done, byte_count);
        end
    endtask

    task automatic test_abort();
        logic [7:0] we;
        bit glitch;
        glitch = 1'b0;
        tick(1'b1, 1'b1, 25'h00200, 8'h10);
        m_wr(25'h00200, 8'h10, we);
        tick(1'b1, 1'b1, 25'h04200, 8'h20);
        m_wr(25'h04200, 8'h20, we);
        tick(1'b0, 1'b0, '0, '0);
        repeat (6) begin
            tick(1'b0, 1'b0, '0, '0);
            if (core_reset !== 1'b1) glitch = 1'b1;
        end
        m_start();
        tick(1'b1, 1'b0, '0, '0);
        if (core_reset !== 1'b1) glitch = 1'b1;
        checks++; if (byte_count !== 17'h0) begin errors++; $display("FAIL t5_count got=%0d exp=0", byte_count); end
        tick(1'b1, 1'b1, 25'h08001, 8'h33);
        m_wr(25'h08001, 8'h33, we);
        if (core_reset !== 1'b1) glitch = 1'b1;
        checks++;
        if (rom_we !== we || byte_count !== 17'(m_count)) begin
            errors++;
            $display("FAIL t5_reload got=%h/%0d exp=%h/%0d", rom_we, byte_count, we, m_count);
        end
        tick(1'b0, 1'b0, '0, '0);
        repeat (HOLD) begin
            tick(1'b0, 1'b0, '0, '0);
            if (core_reset !== 1'b1) glitch = 1'b1;
        end
        checks++; if (glitch) begin errors++; $display("FAIL t5_glitch got=1 exp=0"); end
        repeat (2) tick(1'b0, 1'b0, '0, '0);
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0) begin errors++; $display("FAIL t5_end got=%b/%b exp=1/0", load_done, core_reset); end
    endtask

    task automatic test_zero_byte();
        m_start();
        tick(1'b1, 1'b0, '0, '0);
        repeat (3) tick(1'b1, 1'b0, '0, '0);
        tick(1'b0, 1'b0, '0, '0);
        repeat (HOLD + 4) tick(1'b0, 1'b0, '0, '0);
        checks++;
        if (load_done !== 1'b0 || core_reset !== 1'b1 || byte_count !== 17'h0) begin
            errors++;
            $display("FAIL zero_load got=%b/%b/%0d exp=0/1/0", load_done, core_reset, byte_count);
        end
        checks++; if (checksum_ok !== exp_ok(1'b0, m_sum)) begin errors++; $display("FAIL zero_ok got=%b exp=%b", checksum_ok, exp_ok(1'b0, m_sum)); end
    endtask

    task automatic test_async_reset();
        logic [7:0] we;
        m_start();
        tick(1'b1, 1'b0, '0, '0);
        tick(1'b1, 1'b1, 25'h00010, 8'hAB);
        m_wr(25'h00010, 8'hAB, we);
        tick(1'b1, 1'b0, '0, '0);
        tick(1'b1, 1'b0, '0, '0);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h00011;
        ioctl_dout = 8'hCD;
        #2;
        reset = 1'b1;
        #1;
        m_start();
        m_off = '0;
        m_data = '0;
        checks++;
        if (rom_we !== 8'h00 || core_reset !== 1'b1 || load_done !== 1'b0 ||
            byte_count !== 17'h0 || overrun !== 1'b0 ||
            rom_addr !== 14'h0 || rom_data !== 8'h00 || checksum !== 8'h00) begin
            errors++;
            $display("FAIL t6_async got=%h/%b/%b/%0d/%b/%h/%h/%h exp=00/1/0/0/0/0/00/00",
                     rom_we, core_reset, load_done, byte_count, overrun,
                     rom_addr, rom_data, checksum);
        end
        checks++; if (checksum_ok !== exp_ok(1'b0, m_sum)) begin errors++; $display("FAIL t6_ok got=%b exp=%b", checksum_ok, exp_ok(1'b0, m_sum)); end
        @(posedge clk_sys);
        #1;
        checks++; if (rom_we !== 8'h00) begin errors++; $display("FAIL t6_no_pulse got=%h exp=00", rom_we); end
        reset = 1'b0;
        tick(1'b1, 1'b1, 25'h00020, 8'h01);
        m_wr(25'h00020, 8'h01, we);
        checks++;
        if (byte_count !== 17'(m_count) || rom_we !== we) begin
            errors++;
            $display("FAIL t6_restart got=%0d/%h exp=%0d/%h", byte_count, rom_we, m_count, we);
        end
        tick(1'b0, 1'b0, '0, '0);
        repeat (HOLD + 2) tick(1'b0, 1'b0, '0, '0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL t6_done got=%b exp=1", load_done); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_random_load();
        test_overrun();
        test_abort();
        test_zero_byte();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
